// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI request arbiter: FSM state encoding,
// default parameter values and the per-requester slice widths.
package spi_arb_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_CYC = 64;

    localparam int DATA_W = 8;
    localparam int MODE_W = 2;
    localparam int DIV_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: scans req starting at rr_ptr, wrapping,
// and returns the first asserted requester as one-hot and as an index.
module spi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        winner  = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_req && req[cand]) begin
                any_req      = 1'b1;
                winner[cand] = 1'b1;
                idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters.
// Optional WAIT_BUSY timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                        Pclk,
    input  logic                        Preset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*MODE_W-1:0]   req_mode,
    input  logic [NUM_REQ*DIV_W-1:0]    req_clk_div,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        err,
    output logic [DIV_W-1:0]            m_clk_div,
    output logic [MODE_W-1:0]           m_mode,
    output logic [DATA_W-1:0]           m_write_data,
    output logic                        m_write_en,
    output logic                        m_enable,
    input  logic                        m_busy,
    input  logic [DATA_W-1:0]           m_read_data
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("spi_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (pick_onehot),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // NOTE: all state here is sequential, so every assignment is non-blocking (<=).
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            gnt          <= '0;
            done         <= '0;
            rdata        <= '0;
            m_write_en   <= 1'b0;
            m_enable     <= 1'b0;
            m_write_data <= '0;
            m_mode       <= '0;
            m_clk_div    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            m_write_en <= 1'b0;
            done       <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Latch the winner's settings straight into the master-facing
                    // registers; they then hold steady until the next LOAD.
                    if (pick_any) begin
                        owner        <= pick_idx;
                        gnt          <= pick_onehot;
                        m_write_data <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
                        m_mode       <= req_mode[int'(pick_idx)*MODE_W +: MODE_W];
                        m_clk_div    <= req_clk_div[int'(pick_idx)*DIV_W +: DIV_W];
                        m_write_en   <= 1'b1;
                        m_enable     <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (m_busy) begin
                        state <= WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        rdata    <= '0;
                        m_enable <= 1'b0;
                        done     <= gnt;
                        err_q    <= 1'b1;
                        state    <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!m_busy) begin
                        rdata    <= m_read_data;
                        m_enable <= 1'b0;
                        done     <= gnt;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    gnt    <= '0;
                    rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed self-checking bench for spi_req_arbiter with a small behavioural
// SPI slave; covers the timeout path when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_req_arbiter;

    logic        Pclk;
    logic        Preset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_mode;
    logic [23:0] req_clk_div;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  rdata;
    logic        err;
    logic [5:0]  m_clk_div;
    logic [1:0]  m_mode;
    logic [7:0]  m_write_data;
    logic        m_write_en;
    logic        m_enable;
    logic        m_busy;
    logic [7:0]  m_read_data;

    int vectors     = 0;
    int miscompares = 0;

    // slave model controls
    bit       slave_en = 1'b1;
    int       busy_len = 3;
    logic [7:0] echo   = 8'h00;
    int       busy_cnt = 0;

    // monitor counters
    int cyc      = 0;
    int we_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int we_cyc   = 0;
    int done_cyc = 0;

    spi_req_arbiter #(
        .NUM_REQ     (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .Pclk         (Pclk),
        .Preset       (Preset),
        .req          (req),
        .req_data     (req_data),
        .req_mode     (req_mode),
        .req_clk_div  (req_clk_div),
        .gnt          (gnt),
        .done         (done),
        .rdata        (rdata),
        .err          (err),
        .m_clk_div    (m_clk_div),
        .m_mode       (m_mode),
        .m_write_data (m_write_data),
        .m_write_en   (m_write_en),
        .m_enable     (m_enable),
        .m_busy       (m_busy),
        .m_read_data  (m_read_data)
    );

    initial begin
        Pclk = 1'b0;
        forever #5 Pclk = ~Pclk;
    end

    // Slave: raises busy after a write, holds it busy_len cycles, then returns echo.
    initial begin
        m_busy      = 1'b0;
        m_read_data = 8'h00;
        forever begin
            @(negedge Pclk);
            if (Preset || !m_enable) begin
                busy_cnt = 0;
                m_busy   = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) begin
                    m_busy      = 1'b0;
                    m_read_data = echo;
                end
            end else if (slave_en && m_write_en) begin
                m_busy   = 1'b1;
                busy_cnt = busy_len;
            end
        end
    end

    // Monitor samples just after each rising edge, away from the negedge checks.
    initial begin
        forever begin
            @(posedge Pclk);
            #1;
            cyc = cyc + 1;
            if (m_write_en) begin
                we_cnt = we_cnt + 1;
                we_cyc = cyc;
            end
            if (done != 4'b0) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (err) err_cnt = err_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge Pclk);
            if (done != 4'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_gnt(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge Pclk);
            if (gnt != 4'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_gnt_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic xfer_check(input string tag, input int owner, input logic [7:0] exp_rd);
        logic [3:0] oh;
        oh = 4'b0001 << owner;
        check({tag, "_gnt"},   32'(gnt),   32'(oh));
        check({tag, "_done"},  32'(done),  32'(oh));
        check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        check({tag, "_err"},   32'(err),   32'd0);
        check({tag, "_wdata"}, 32'(m_write_data), 32'(req_data[owner*8 +: 8]));
        check({tag, "_mode"},  32'(m_mode),       32'(req_mode[owner*2 +: 2]));
        check({tag, "_div"},   32'(m_clk_div),    32'(req_clk_div[owner*6 +: 6]));
    endtask

    initial begin
        int d0;
        int w0;
        Preset      = 1'b1;
        req         = 4'b0000;
        req_data    = '0;
        req_mode    = '0;
        req_clk_div = '0;

        // reset state
        repeat (3) @(negedge Pclk);
        check("rst_gnt",    32'(gnt),          32'd0);
        check("rst_done",   32'(done),         32'd0);
        check("rst_err",    32'(err),          32'd0);
        check("rst_rdata",  32'(rdata),        32'd0);
        check("rst_we",     32'(m_write_en),   32'd0);
        check("rst_en",     32'(m_enable),     32'd0);
        check("rst_wdata",  32'(m_write_data), 32'd0);
        check("rst_mode",   32'(m_mode),       32'd0);
        check("rst_div",    32'(m_clk_div),    32'd0);
        Preset = 1'b0;
        repeat (2) @(negedge Pclk);

        // single request on 1; req dropped right after grant must not abort
        req_data[15:8]   = 8'hA5;
        req_mode[3:2]    = 2'b01;
        req_clk_div[11:6] = 6'd4;
        echo     = 8'h3C;
        busy_len = 4;
        req      = 4'b0010;
        wait_gnt("single", 10);
        check("single_load_gnt",   32'(gnt),          32'h2);
        check("single_load_we",    32'(m_write_en),   32'd1);
        check("single_load_wdata", 32'(m_write_data), 32'hA5);
        check("single_load_en",    32'(m_enable),     32'd1);
        req = 4'b0000;
        wait_done("single", 60);
        xfer_check("single", 1, 8'h3C);
        check("single_en_off", 32'(m_enable), 32'd0);
        @(negedge Pclk);
        check("single_done_pulse", 32'(done),     32'd0);
        check("single_gnt_clear",  32'(gnt),      32'd0);
        check("single_we_count",   32'(we_cnt),   32'd1);
        check("single_done_count", 32'(done_cnt), 32'd1);

        // all four requesting from reset: grants 0,1,2,3,0
        Preset      = 1'b1;
        req_data    = 32'h44332211;
        req_mode    = 8'b11_10_01_00;
        req_clk_div = {6'd11, 6'd10, 6'd9, 6'd8};
        req         = 4'b1111;
        busy_len    = 3;
        echo        = 8'h80;
        @(negedge Pclk);
        Preset = 1'b0;
        d0 = done_cnt;
        w0 = we_cnt;
        for (int k = 0; k < 5; k++) begin
            wait_done($sformatf("rr%0d", k), 60);
            xfer_check($sformatf("rr%0d", k), k % 4, 8'h80 + 8'(k));
            echo = 8'h81 + 8'(k);
            if (k == 4) req = 4'b0100;
            @(negedge Pclk);
            check($sformatf("rr%0d_done_pulse", k), 32'(done), 32'd0);
            check($sformatf("rr%0d_idle_gap", k),   32'(gnt),  32'd0);
        end
        check("rr_done_count", 32'(done_cnt - d0), 32'd5);
        check("rr_we_count",   32'(we_cnt - w0),   32'd5);

        // owner 2, then 0101 must wrap to 0 before 2
        echo = 8'h52;
        wait_done("own2", 60);
        xfer_check("own2", 2, 8'h52);
        req  = 4'b0101;
        echo = 8'h50;
        wait_done("wrap0", 60);
        xfer_check("wrap0", 0, 8'h50);
        echo = 8'h25;
        wait_done("then2", 60);
        xfer_check("then2", 2, 8'h25);
        req = 4'b0100;

        // reset while WAIT_DONE: abort, then restart from rr_ptr=0
        busy_len = 20;
        echo     = 8'h77;
        begin
            bit busy_seen;
            busy_seen = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge Pclk);
                if (m_busy) begin
                    busy_seen = 1'b1;
                    break;
                end
            end
            check("abort_busy_seen", 32'(busy_seen), 32'd1);
        end
        repeat (2) @(negedge Pclk);
        d0     = done_cnt;
        Preset = 1'b1;
        req    = 4'b1001;
        @(negedge Pclk);
        check("abort_en",   32'(m_enable), 32'd0);
        check("abort_gnt",  32'(gnt),      32'd0);
        check("abort_done", 32'(done),     32'd0);
        Preset   = 1'b0;
        busy_len = 3;
        echo     = 8'h66;
        wait_done("post_rst", 100);
        check("post_rst_gnt",   32'(gnt),             32'h1);
        check("post_rst_rdata", 32'(rdata),           32'h66);
        check("post_rst_dcnt",  32'(done_cnt - d0),   32'd1);

`ifdef SPI_ARB_TIMEOUT_EN
        // no busy from the slave: 64 WAIT_BUSY cycles then err with done
        slave_en = 1'b0;
        req      = 4'b1000;
        wait_done("tmo", 200);
        check("tmo_done",  32'(done),     32'h8);
        check("tmo_err",   32'(err),      32'd1);
        check("tmo_rdata", 32'(rdata),    32'd0);
        check("tmo_en",    32'(m_enable), 32'd0);
        check("tmo_gap",   32'(done_cyc - we_cyc), 32'd65);
        req = 4'b0000;
        @(negedge Pclk);
        check("tmo_err_pulse", 32'(err),  32'd0);
        check("tmo_gnt_clear", 32'(gnt),  32'd0);
        check("tmo_done_clr",  32'(done), 32'd0);
        slave_en = 1'b1;
`else
        // no busy from the slave: arbiter waits indefinitely, err stays 0
        slave_en = 1'b0;
        req      = 4'b1000;
        d0       = done_cnt;
        repeat (80) @(negedge Pclk);
        check("hang_dcnt", 32'(done_cnt - d0), 32'd0);
        check("hang_gnt",  32'(gnt),           32'h8);
        check("hang_en",   32'(m_enable),      32'd1);
        m_busy = 1'b1;
        repeat (2) @(negedge Pclk);
        m_read_data = 8'h9E;
        m_busy      = 1'b0;
        req         = 4'b0000;
        wait_done("hang_end", 20);
        check("hang_done",  32'(done),  32'h8);
        check("hang_rdata", 32'(rdata), 32'h9E);
        check("hang_errcnt", 32'(err_cnt), 32'd0);
        slave_en = 1'b1;
`endif

        repeat (3) @(negedge Pclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
